// File: rtl/clkswitch_sync_if.sv
// Clock-switch control/status bundle: host clock, mode request and divider in,
// selected-mode flags, CPU clock and cycle strobe out.
interface clkswitch_sync_if #(
    parameter int unsigned DIV_W = 3
);
    logic             lsclk_in;
    logic             hsclk_sel;
    logic [DIV_W-1:0] cpuclk_div_sel;
    logic             hsclk_selected;
    logic             lsclk_selected;
    logic             clkout;
    logic             cycle_strobe;

    modport master (
        output lsclk_in, hsclk_sel, cpuclk_div_sel,
        input  hsclk_selected, lsclk_selected, clkout, cycle_strobe
    );

    modport slave (
        input  lsclk_in, hsclk_sel, cpuclk_div_sel,
        output hsclk_selected, lsclk_selected, clkout, cycle_strobe
    );
endinterface

// File: rtl/clkswitch_sync.sv
// Synchronous CPU clock generator: divided hsclk_in (HS) or delay-matched lsclk_in (LS),
// with glitch-free changeover that parks clkout high across the switch.
module clkswitch_sync #(
    parameter int unsigned DIV_W  = 3,
    parameter int unsigned LS_DEL = 3
) (
    input  logic            hsclk_in,
    input  logic            rst_b,
    clkswitch_sync_if.slave bus
);

    typedef enum logic [1:0] {
        ST_LS      = 2'd0,
        ST_PARK_HS = 2'd1,
        ST_HS      = 2'd2,
        ST_PARK_LS = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             clk_q, clk_nxt;
    logic             strobe_q, strobe_nxt;
    logic             hs_sel_q, hs_nxt;
    logic             ls_sel_q, ls_nxt;

    logic [LS_DEL-1:0] ls_pipe;
    logic              ls_del_prev;
    logic              ls_del;
    logic              ls_rise;

    // First two stages double as the metastability synchroniser for the async host clock.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            ls_pipe     <= '0;
            ls_del_prev <= 1'b0;
        end else begin
            ls_pipe     <= {ls_pipe[LS_DEL-2:0], bus.lsclk_in};
            ls_del_prev <= ls_pipe[LS_DEL-1];
        end
    end

    assign ls_del  = ls_pipe[LS_DEL-1];
    assign ls_rise = ls_del & ~ls_del_prev;

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_LS;
            cnt      <= '0;
            div_q    <= '0;
            clk_q    <= 1'b0;
            strobe_q <= 1'b0;
            hs_sel_q <= 1'b0;
            ls_sel_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            div_q    <= div_nxt;
            clk_q    <= clk_nxt;
            strobe_q <= strobe_nxt;
            hs_sel_q <= hs_nxt;
            ls_sel_q <= ls_nxt;
        end
    end

    // Mode changes only leave a high phase, so clkout never shows a runt or low glitch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_q;
        clk_nxt   = clk_q;
        hs_nxt    = hs_sel_q;
        ls_nxt    = ls_sel_q;
        case (state)
            ST_LS: begin
                clk_nxt = ls_del;
                if (bus.hsclk_sel && ls_rise) begin
                    state_nxt = ST_PARK_HS;
                    clk_nxt   = 1'b1;
                    ls_nxt    = 1'b0;
                    div_nxt   = bus.cpuclk_div_sel;
                    cnt_nxt   = '0;
                end
            end
            ST_PARK_HS: begin
                clk_nxt = 1'b1;
                if (!bus.hsclk_sel) begin
                    state_nxt = ST_PARK_LS;
                end else if (cnt == div_q) begin
                    state_nxt = ST_HS;
                    clk_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    hs_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            ST_HS: begin
                if (cnt != div_q) begin
                    cnt_nxt = cnt + DIV_W'(1);
                end else if (!clk_q) begin
                    // Ratio updates only at the start of a full cycle.
                    clk_nxt = 1'b1;
                    cnt_nxt = '0;
                    div_nxt = bus.cpuclk_div_sel;
                end else if (!bus.hsclk_sel) begin
                    state_nxt = ST_PARK_LS;
                    hs_nxt    = 1'b0;
                end else begin
                    clk_nxt = 1'b0;
                    cnt_nxt = '0;
                end
            end
            ST_PARK_LS: begin
                clk_nxt = 1'b1;
                if (ls_rise) begin
                    state_nxt = ST_LS;
                    ls_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LS;
            end
        endcase
        strobe_nxt = clk_nxt & ~clk_q;
    end

    assign bus.clkout         = clk_q;
    assign bus.cycle_strobe   = strobe_q;
    assign bus.hsclk_selected = hs_sel_q;
    assign bus.lsclk_selected = ls_sel_q;

endmodule
